// File: rtl/tybec_stream_pkg.sv
// Shared definitions for the tybec stream stages: FSM state encoding and a
// constant clog2 used to size counters from elaboration parameters.
package tybec_stream_pkg;

    localparam logic [0:0] ST_ACCUM_ENC = 1'b0;
    localparam logic [0:0] ST_HOLD_ENC  = 1'b1;

    typedef enum logic [0:0] {
        ACCUM = ST_ACCUM_ENC,
        HOLD  = ST_HOLD_ENC
    } state_t;

    // Smallest r with 2**r >= value; evaluated at elaboration time only.
    function automatic int clog2(input int value);
        int result;
        longint span;
        result = 0;
        span   = 64'sd1;
        for (int i = 0; i < 32; i++) begin
            if (span < longint'(value)) begin
                span   = span << 1;
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/orModule.sv
// Team bitwise OR core: y = a | b across N bits, purely combinational.
module orModule #(
    parameter int N = 18
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = a | b;

endmodule

// File: rtl/or_reduce_stream.sv
// Streaming OR-reduction: ORs each frame of up to LEN words (or until in_last)
// and presents the result on a registered valid/ready output.
module or_reduce_stream
    import tybec_stream_pkg::*;
#(
    parameter int N   = 18,
    parameter int LEN = 16,
    parameter int CW  = clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  acc_r;
    logic [N-1:0]  acc_nxt_s;
    logic [N-1:0]  or_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [CW-1:0] cnt_inc_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          emit_s;

    orModule #(.N(N)) u_or (
        .a (acc_r),
        .b (in_data),
        .y (or_s)
    );

    assign cnt_inc_s = cnt_r + CW'(1);
    assign accept_s  = in_valid & in_ready_s;
    assign emit_s    = (state_r == HOLD) & out_ready;

    // State, accumulator and word counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ACCUM;
            acc_r   <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state: accumulate in ACCUM; in HOLD an emit either clears or,
    // with a simultaneous accept, loads the new word so frames abut.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ACCUM: begin
                if (accept_s) begin
                    acc_nxt_s = or_s;
                    cnt_nxt_s = cnt_inc_s;
                    if ((cnt_inc_s == CW'(LEN)) || in_last) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (emit_s) begin
                    if (accept_s) begin
                        acc_nxt_s = in_data;
                        cnt_nxt_s = CW'(1);
                        if ((LEN == 1) || in_last) begin
                            state_nxt_s = HOLD;
                        end else begin
                            state_nxt_s = ACCUM;
                        end
                    end else begin
                        acc_nxt_s   = {N{1'b0}};
                        cnt_nxt_s   = {CW{1'b0}};
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                acc_nxt_s   = {N{1'b0}};
                cnt_nxt_s   = {CW{1'b0}};
                state_nxt_s = ACCUM;
            end
        endcase
    end

    // Ready: always open while accumulating, follows downstream while holding.
    always_comb begin
        in_ready_s = 1'b1;
        case (state_r)
            ACCUM:   in_ready_s = 1'b1;
            HOLD:    in_ready_s = out_ready;
            default: in_ready_s = 1'b1;
        endcase
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == HOLD);
    assign out_data  = acc_r;
    assign out_count = cnt_r;

endmodule

// File: tb/tb_or_reduce_stream.sv
// Self-checking bench for or_reduce_stream: a LEN=4 and a LEN=1 instance share
// stimulus; a frame-level reference model plus directed tables check both.
module tb_or_reduce_stream;

    localparam int N = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;

    logic         rdy4, vld4;
    logic [N-1:0] dat4;
    logic [2:0]   cnt4;
    logic         rdy1, vld1;
    logic [N-1:0] dat1;
    logic [0:0]   cnt1;

    always #5 clk = ~clk;

    or_reduce_stream #(.N(N), .LEN(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy4), .in_last(in_last), .out_data(dat4),
        .out_count(cnt4), .out_valid(vld4), .out_ready(out_ready)
    );

    or_reduce_stream #(.N(N), .LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .in_last(in_last), .out_data(dat1),
        .out_count(cnt1), .out_valid(vld1), .out_ready(out_ready)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one pending closed frame per instance plus the frame
    // being gathered, updated per handshake from the frame rules.
    int           lens [2] = '{4, 1};
    logic [N-1:0] m_cur  [2];
    int           m_n    [2];
    logic         m_pend [2];
    logic [N-1:0] m_pdat [2];
    int           m_pcnt [2];
    int           m_emits[2];

    typedef struct {
        logic [3:0][N-1:0] w;
        int                n;
        logic              close;
        logic [N-1:0]      exp_data;
        int                exp_cnt;
    } frame_t;

    frame_t frames[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cur[i]  = '0;
            m_n[i]    = 0;
            m_pend[i] = 1'b0;
            m_pdat[i] = '0;
            m_pcnt[i] = 0;
        end
    endtask

    task automatic check_inst(input int i, input logic rdy, input logic vld,
                              input logic [N-1:0] d, input int c);
        check($sformatf("in_ready[len%0d]", lens[i]), 32'(rdy), 32'(!m_pend[i] || out_ready));
        check($sformatf("out_valid[len%0d]", lens[i]), 32'(vld), 32'(m_pend[i]));
        if (m_pend[i]) begin
            check($sformatf("out_data[len%0d]", lens[i]), 32'(d), 32'(m_pdat[i]));
            check($sformatf("out_count[len%0d]", lens[i]), 32'(c), 32'(m_pcnt[i]));
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            logic rdy_m;
            logic acc_m;
            rdy_m = !m_pend[i] || out_ready;
            acc_m = in_valid && rdy_m;
            if (m_pend[i] && out_ready) begin
                m_pend[i] = 1'b0;
                m_emits[i]++;
            end
            if (acc_m) begin
                m_cur[i] = m_cur[i] | in_data;
                m_n[i]++;
                if (m_n[i] == lens[i] || in_last) begin
                    m_pend[i] = 1'b1;
                    m_pdat[i] = m_cur[i];
                    m_pcnt[i] = m_n[i];
                    m_cur[i]  = '0;
                    m_n[i]    = 0;
                end
            end
        end
    endtask

    // One clock cycle: drive at negedge, compare just before the rising edge.
    task automatic step(input logic [N-1:0] d, input logic v, input logic l, input logic r);
        @(negedge clk);
        in_data   = d;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        #4;
        check_inst(0, rdy4, vld4, dat4, int'(cnt4));
        check_inst(1, rdy1, vld1, dat1, int'(cnt1));
        model_update();
        @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld4"}, 32'(vld4), 32'd0);
        check({tag, "_dat4"}, 32'(dat4), 32'd0);
        check({tag, "_cnt4"}, 32'(cnt4), 32'd0);
        check({tag, "_rdy4"}, 32'(rdy4), 32'd1);
        check({tag, "_vld1"}, 32'(vld1), 32'd0);
        check({tag, "_dat1"}, 32'(dat1), 32'd0);
        check({tag, "_rdy1"}, 32'(rdy1), 32'd1);
    endtask

    initial begin
        int e0;
        logic [N-1:0] w;

        frames[0] = '{{18'h01000, 18'h00100, 18'h00010, 18'h00001}, 4, 1'b0, 18'h01111, 4};
        frames[1] = '{{18'h00000, 18'h00000, 18'h0000F, 18'h30000}, 2, 1'b1, 18'h3000F, 2};
        frames[2] = '{{18'h00000, 18'h00000, 18'h00000, 18'h20001}, 1, 1'b1, 18'h20001, 1};
        frames[3] = '{{18'h10000, 18'h00008, 18'h00004, 18'h00002}, 4, 1'b1, 18'h1000E, 4};
        m_emits[0] = 0;
        m_emits[1] = 0;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed frames: full, early close, single word, last on LEN-th word.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < frames[f].n; k++) begin
                step(frames[f].w[k], 1'b1, frames[f].close && (k == frames[f].n - 1), 1'b1);
            end
            #1;
            check($sformatf("frame%0d_valid", f), 32'(vld4), 32'd1);
            check($sformatf("frame%0d_data", f), 32'(dat4), 32'(frames[f].exp_data));
            check($sformatf("frame%0d_count", f), 32'(cnt4), 32'(frames[f].exp_cnt));
        end
        step('0, 1'b0, 1'b0, 1'b1);
        #1;
        check("no_empty_frame", 32'(vld4), 32'd0);

        // Back-to-back: two frames, second must not carry the first's bits.
        e0 = m_emits[0];
        for (int k = 0; k < 4; k++) step(18'h3FFC0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(N'(1 << k), 1'b1, 1'b0, 1'b1);
        #1;
        check("b2b_data", 32'(dat4), 32'h0000F);
        check("b2b_count", 32'(cnt4), 32'd4);
        step('0, 1'b0, 1'b0, 1'b1);
        check("b2b_emits", 32'(m_emits[0] - e0), 32'd2);

        // Backpressure: outputs frozen, then emit and accept in one cycle.
        step(18'h00003, 1'b1, 1'b0, 1'b1);
        step(18'h00030, 1'b1, 1'b0, 1'b1);
        step(18'h00300, 1'b1, 1'b0, 1'b1);
        step(18'h03000, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(18'h3FFFF, 1'b1, 1'b0, 1'b0);
            #1;
            check("bp_stable_data", 32'(dat4), 32'h03333);
            check("bp_stable_count", 32'(cnt4), 32'd4);
        end
        step(18'h00005, 1'b1, 1'b0, 1'b1);
        #1;
        check("bp_release_valid", 32'(vld4), 32'd0);
        check("bp_release_count", 32'(cnt4), 32'd1);
        check("bp_release_data", 32'(dat4), 32'h00005);
        step(18'h00010, 1'b1, 1'b0, 1'b1);
        step(18'h00020, 1'b1, 1'b0, 1'b1);
        step(18'h00040, 1'b1, 1'b0, 1'b1);
        #1;
        check("bp_next_frame", 32'(dat4), 32'h00075);
        step('0, 1'b0, 1'b0, 1'b1);

        // Mid-frame asynchronous reset between edges.
        step(18'h2AAAA, 1'b1, 1'b0, 1'b1);
        step(18'h15555, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(N'(18'h00100 << k), 1'b1, 1'b0, 1'b1);
        #1;
        check("post_reset_data", 32'(dat4), 32'h00F00);
        check("post_reset_count", 32'(cnt4), 32'd4);
        step('0, 1'b0, 1'b0, 1'b1);

        // LEN=1: every word is its own frame, full rate.
        for (int k = 0; k < 6; k++) begin
            w = N'($urandom);
            step(w, 1'b1, 1'b0, 1'b1);
            #1;
            check("len1_valid", 32'(vld1), 32'd1);
            check("len1_count", 32'(cnt1), 32'd1);
            check("len1_data", 32'(dat1), 32'(w));
        end
        step('0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            step(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
